// File: rtl/biriscv_defs.sv
// Shared definitions for the icache arbiter: owner tag encodings and the tag layout
// held in the in-order tracking FIFO.
package biriscv_defs;

    localparam logic ARB_OWNER_FETCH = 1'b0;
    localparam logic ARB_OWNER_PF    = 1'b1;

    localparam int ARB_TAG_W = 2;

    typedef struct packed {
        logic discard;
        logic owner;
    } arb_tag_t;

endpackage

// File: rtl/biriscv_icache_arb_fifo.sv
// In-order tag FIFO for outstanding icache reads. The top bit of each entry is a
// discard flag that can be set in place on any slot; bit 0 is the owner.
module biriscv_icache_arb_fifo #(
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = 2,
    parameter int WIDTH   = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               push_i,
    input  logic [WIDTH-1:0]   push_data_i,
    input  logic               pop_i,
    input  logic [DEPTH-1:0]   discard_set_i,
    output logic [WIDTH-1:0]   head_o,
    output logic [DEPTH-1:0]   owner_o,
    output logic [DEPTH_W:0]   count_o
);

    localparam logic [DEPTH_W:0] FULL_CNT = (DEPTH_W + 1)'(DEPTH);

    logic [DEPTH_W-1:0]            wr_ptr_reg;
    logic [DEPTH_W-1:0]            rd_ptr_reg;
    logic [DEPTH_W:0]              count_reg;
    logic [DEPTH-1:0][WIDTH-1:0]   entries;
    logic                          push_ok;
    logic                          pop_ok;

    assign push_ok = push_i && (count_reg != FULL_CNT);
    assign pop_ok  = pop_i && (count_reg != '0);

    // Entries live in flops: the discard flag is updated on many slots at once.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    entry_reg <= '0;
                end else if (push_ok && (wr_ptr_reg == DEPTH_W'(gi))) begin
                    entry_reg <= push_data_i;
                end else if (discard_set_i[gi]) begin
                    entry_reg[WIDTH-1] <= 1'b1;
                end
            end

            assign entries[gi] = entry_reg;
            assign owner_o[gi] = entry_reg[0];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_reg <= count_reg - 1'b1;
            end
        end
    end

    assign head_o  = entries[rd_ptr_reg];
    assign count_o = count_reg;

endmodule

// File: rtl/biriscv_icache_arb.sv
// Two-requester icache read arbiter (fetch / prefetch) with in-order response routing.
// Define ICACHE_ARB_RR_EN for round-robin arbitration; default is fixed priority (fetch first).
module biriscv_icache_arb
    import biriscv_defs::*;
#(
    parameter int DEPTH   = 4,
    parameter int DEPTH_W = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        req0_rd_i,
    input  logic [31:0] req0_pc_i,
    input  logic [1:0]  req0_priv_i,
    input  logic        req0_abort_i,
    output logic        req0_accept_o,
    output logic        req0_valid_o,
    output logic [63:0] req0_inst_o,
    output logic        req0_error_o,
    output logic        req0_page_fault_o,

    input  logic        req1_rd_i,
    input  logic [31:0] req1_pc_i,
    input  logic [1:0]  req1_priv_i,
    output logic        req1_accept_o,
    output logic        req1_valid_o,
    output logic [63:0] req1_inst_o,
    output logic        req1_error_o,
    output logic        req1_page_fault_o,

    output logic        icache_rd_o,
    output logic [31:0] icache_pc_o,
    output logic [1:0]  icache_priv_o,
    input  logic        icache_accept_i,
    input  logic        icache_valid_i,
    input  logic [63:0] icache_inst_i,
    input  logic        icache_error_i,
    input  logic        icache_page_fault_i,

    output logic        busy_o
);

    localparam logic [DEPTH_W:0] FULL_CNT = (DEPTH_W + 1)'(DEPTH);

    logic        lock_reg;
    logic        grant_reg;
    logic [31:0] pc_reg;
    logic [1:0]  priv_reg;
    logic        rr_reg;

    logic        grant;
    logic        req_rd;
    logic [31:0] issue_pc;
    logic [1:0]  issue_priv;
    logic        accept_fire;

    logic [DEPTH_W:0]   count;
    logic [DEPTH-1:0]   owners;
    logic [DEPTH-1:0]   discard_set;
    logic [ARB_TAG_W-1:0] head;
    arb_tag_t           head_tag;
    arb_tag_t           push_tag;
    logic               pop;
    logic               deliver;

    // A locked grant sticks until the icache takes the request.
    always_comb begin
        grant = ARB_OWNER_FETCH;
        if (lock_reg) begin
            grant = grant_reg;
        end
`ifdef ICACHE_ARB_RR_EN
        else if (req0_rd_i && req1_rd_i) begin
            grant = rr_reg;
        end
`endif
        else if (!req0_rd_i && req1_rd_i) begin
            grant = ARB_OWNER_PF;
        end
    end

    always_comb begin
        req_rd     = 1'b0;
        issue_pc   = '0;
        issue_priv = '0;
        if (lock_reg) begin
            req_rd     = 1'b1;
            issue_pc   = pc_reg;
            issue_priv = priv_reg;
        end else if (grant == ARB_OWNER_PF) begin
            req_rd     = req1_rd_i;
            issue_pc   = req1_pc_i;
            issue_priv = req1_priv_i;
        end else begin
            req_rd     = req0_rd_i;
            issue_pc   = req0_pc_i;
            issue_priv = req0_priv_i;
        end
    end

    assign icache_rd_o   = !rst_i && req_rd && (count != FULL_CNT)
                           && !((grant == ARB_OWNER_FETCH) && req0_abort_i);
    assign icache_pc_o   = icache_rd_o ? issue_pc : 32'd0;
    assign icache_priv_o = icache_rd_o ? issue_priv : 2'd0;

    assign accept_fire   = icache_rd_o && icache_accept_i;
    assign req0_accept_o = accept_fire && (grant == ARB_OWNER_FETCH);
    assign req1_accept_o = accept_fire && (grant == ARB_OWNER_PF);

    // rr_reg holds the requester preferred on the next tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_reg  <= 1'b0;
            grant_reg <= ARB_OWNER_FETCH;
            pc_reg    <= '0;
            priv_reg  <= '0;
            rr_reg    <= ARB_OWNER_FETCH;
        end else begin
            lock_reg  <= icache_rd_o && !icache_accept_i;
            grant_reg <= grant;
            pc_reg    <= issue_pc;
            priv_reg  <= issue_priv;
            if (accept_fire) begin
                rr_reg <= ~grant;
            end
        end
    end

    // Abort marks every fetch-owned slot; stale slots are harmless since a push rewrites them.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_discard
            assign discard_set[gi] = req0_abort_i && (owners[gi] == ARB_OWNER_FETCH);
        end
    endgenerate

    assign push_tag.owner   = grant;
    assign push_tag.discard = req0_abort_i && (grant == ARB_OWNER_FETCH);
    assign pop              = !rst_i && icache_valid_i && (count != '0);

    biriscv_icache_arb_fifo #(
        .DEPTH   (DEPTH),
        .DEPTH_W (DEPTH_W),
        .WIDTH   (ARB_TAG_W)
    ) u_fifo (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .push_i        (accept_fire),
        .push_data_i   (push_tag),
        .pop_i         (pop),
        .discard_set_i (discard_set),
        .head_o        (head),
        .owner_o       (owners),
        .count_o       (count)
    );

    assign head_tag = head;

    // A fetch response landing in the abort cycle belongs to the squashed stream.
    assign deliver = pop && !head_tag.discard
                     && !((head_tag.owner == ARB_OWNER_FETCH) && req0_abort_i);

    assign req0_valid_o      = deliver && (head_tag.owner == ARB_OWNER_FETCH);
    assign req1_valid_o      = deliver && (head_tag.owner == ARB_OWNER_PF);
    assign req0_inst_o       = req0_valid_o ? icache_inst_i : 64'd0;
    assign req1_inst_o       = req1_valid_o ? icache_inst_i : 64'd0;
    assign req0_error_o      = req0_valid_o && icache_error_i;
    assign req1_error_o      = req1_valid_o && icache_error_i;
    assign req0_page_fault_o = req0_valid_o && icache_page_fault_i;
    assign req1_page_fault_o = req1_valid_o && icache_page_fault_i;

    assign busy_o = (count != '0);

endmodule

// File: doc/biriscv_icache_arb.md
BIRISCV_ICACHE_ARB -- requirements
Module: biriscv_icache_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 4: maximum outstanding icache reads (power of 2, at least 2).
REQ-002 SHALL have parameter DEPTH_W, default 2: log2(DEPTH).
REQ-003 SHALL have ports clk_i in 1 (single clock) and rst_i in 1 (reset, synchronous, active-high).
REQ-004 SHALL have requester 0 (fetch) ports:
- req0_rd_i in 1
- req0_pc_i in 32
- req0_priv_i in 2
- req0_abort_i in 1: branch/flush; discard pending req0 responses
- req0_accept_o out 1
- req0_valid_o out 1
- req0_inst_o out 64
- req0_error_o out 1
- req0_page_fault_o out 1
REQ-005 SHALL have requester 1 (prefetch) ports:
- req1_rd_i in 1
- req1_pc_i in 32
- req1_priv_i in 2
- req1_accept_o out 1
- req1_valid_o out 1
- req1_inst_o out 64
- req1_error_o out 1
- req1_page_fault_o out 1
REQ-006 SHALL have icache-side ports:
- icache_rd_o out 1
- icache_pc_o out 32
- icache_priv_o out 2
- icache_accept_i in 1
- icache_valid_i in 1
- icache_inst_i in 64
- icache_error_i in 1
- icache_page_fault_i in 1
REQ-007 SHALL have port busy_o out 1: one or more reads are outstanding.

Function
REQ-010 Grant: SHALL compute the grant from the rd inputs when unlocked; req0 wins by default (see REQ-030).
REQ-011 Lock: if icache_rd_o=1 and icache_accept_i=0, SHALL hold the grant, pc and priv unchanged into the next cycle.
REQ-012 Issue: icache_rd_o=1 when the granted req is asserted, count<DEPTH, and (for req0) req0_abort_i=0.
REQ-013 Issue mux: icache_pc_o and icache_priv_o SHALL be a combinational mux of the granted requester's inputs.
REQ-014 Accept: reqN_accept_o = icache_accept_i & icache_rd_o & (grant==N); zero-latency pass-through.
REQ-015 Tracking: each accepted read SHALL push {owner, discard=0} into the in-order tag FIFO.
REQ-016 Response routing: icache_valid_i SHALL pop the head tag and, in the same cycle, drive the owner's valid/inst/error/page_fault.
REQ-017 Discarded responses: if the head discard=1, the response SHALL pop silently with no valid output.
REQ-018 Abort: req0_abort_i SHALL set discard on every in-flight req0 tag that cycle, including a tag pushed in the same cycle.
REQ-019 Abort vs. response: a req0 response arriving in the abort cycle SHALL be suppressed.
REQ-020 Abort scope: req1 tags are unaffected by abort.
REQ-021 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-022 Full: when count==DEPTH, icache_rd_o=0; a pop in that cycle does not enable an issue until the next cycle.
REQ-023 Empty: icache_valid_i with count==0 SHALL be ignored with no output; the FIFO must not underflow.
REQ-024 Response data: reqN_inst_o SHALL be 0 when reqN_valid_o=0.
REQ-025 busy_o = (count!=0).

Reset
REQ-026 While rst_i is high at the clock edge, the block SHALL clear count, pointers, lock and the round-robin pointer.
REQ-027 All outputs SHALL be 0 during and after reset until a new request; in-flight responses arriving after reset are dropped under REQ-023.

Configuration
REQ-030 With ICACHE_ARB_RR_EN defined, unlocked arbitration SHALL be round-robin: the last-granted requester loses a tie.
REQ-031 Without ICACHE_ARB_RR_EN, arbitration SHALL be fixed priority, req0 over req1.

Structure
REQ-032 Owner tag encodings (ARB_OWNER_FETCH=0, ARB_OWNER_PF=1) SHALL reside in the shared biriscv_defs include.
REQ-033 The tag FIFO SHALL be sub-module biriscv_icache_arb_fifo (DEPTH, width 2, with a per-entry discard-set input); the arbiter, lock and routing stay at top level.

Verification
REQ-040 Fixed priority: req0 and req1 both asserted, pc 0x1000 and 0x2000, accept=1 -> icache_pc_o=0x1000 and req0_accept_o=1; next cycle (req0 low) icache_pc_o=0x2000.
REQ-041 Lock: req1 granted, accept=0 for 3 cycles while req0 rises -> icache_pc_o holds req1's pc until accepted.
REQ-042 Abort: two req0 reads outstanding, abort pulses, then two icache_valid_i -> req0_valid_o never asserts, busy_o falls after the second pop.
REQ-043 Full: four reads accepted with no response -> icache_rd_o=0; one response -> issue resumes the following cycle.
REQ-044 Interleave plus RR (macro defined): alternating req0 and req1 reads with responses in order -> each response routed to its owner; grants alternate 0,1,0,1.
REQ-045 Reset mid-operation: rst_i with 3 outstanding, then 3 stray icache_valid_i -> no reqN_valid_o and count stays 0.
